// File: rtl/clock_set_controller_pkg.sv
// Shared types, field widths, limits and reset defaults for the clock-set controller.
package clock_set_controller_pkg;

  localparam int HOURS_W   = 5;
  localparam int MINUTES_W = 6;

  localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
  localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;
  localparam logic [HOURS_W-1:0]   HOURS_RST   = 5'd12;
  localparam logic [MINUTES_W-1:0] MINUTES_RST = 6'd0;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_SET_HOURS   = 2'd1,
    ST_SET_MINUTES = 2'd2
  } state_e;

  // Wrap by explicit compare so out-of-range codes can never be produced.
  function automatic logic [HOURS_W-1:0] inc_hours(input logic [HOURS_W-1:0] h);
    return (h >= HOURS_MAX) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [MINUTES_W-1:0] inc_minutes(input logic [MINUTES_W-1:0] m);
    return (m >= MINUTES_MAX) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Key, live-time, counter-load and display signals of the clock-set controller.
interface clock_set_controller_if;
  import clock_set_controller_pkg::*;

  logic                 key_mode;
  logic                 key_inc;
  logic [HOURS_W-1:0]   cur_hours;
  logic [MINUTES_W-1:0] cur_minutes;
  logic                 run_en;
  logic                 load;
  logic [HOURS_W-1:0]   load_hours;
  logic [MINUTES_W-1:0] load_minutes;
  logic [HOURS_W-1:0]   disp_hours;
  logic [MINUTES_W-1:0] disp_minutes;
  logic                 blank_hours;
  logic                 blank_minutes;
  logic                 editing;

  modport master (
    output key_mode, key_inc, cur_hours, cur_minutes,
    input  run_en, load, load_hours, load_minutes,
    input  disp_hours, disp_minutes, blank_hours, blank_minutes, editing
  );

  modport slave (
    input  key_mode, key_inc, cur_hours, cur_minutes,
    output run_en, load, load_hours, load_minutes,
    output disp_hours, disp_minutes, blank_hours, blank_minutes, editing
  );

endinterface

// File: rtl/clock_set_controller_key_conditioner.sv
// One pushbutton: two-flop synchronizer, debounce, rising-edge pulse, optional auto-repeat.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic pulse
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_dly_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic             rise, rpt_fire;

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d  = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign rise     = level_q & ~level_dly_q;
  assign rpt_fire = REPEAT_EN && level_q &&
                    (rpt_cnt_q == (rpt_phase_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));
  assign pulse    = rise | rpt_fire;

  // rpt_cnt counts cycles since the last emitted pulse; phase selects delay vs period.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    if (!REPEAT_EN || !level_q) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (rise || rpt_fire) begin
      rpt_cnt_d   = RPT_W'(1);
      rpt_phase_d = rpt_phase_q | rpt_fire;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Run / set-hours / set-minutes controller: freezes the counter while editing, blinks the
// field being edited, and commits the edited time with a one-cycle load strobe.
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int BLINK_HALF      = 12_500_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                   clk_50MHz,
  input  logic                   reset,
  clock_set_controller_if.slave  bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);

  localparam logic [1:0] RUN         = ST_RUN;
  localparam logic [1:0] SET_HOURS   = ST_SET_HOURS;
  localparam logic [1:0] SET_MINUTES = ST_SET_MINUTES;

  logic                 mode_p, inc_p;
  logic [1:0]           state_q, state_d;
  logic [HOURS_W-1:0]   edit_hours_q, edit_hours_d;
  logic [MINUTES_W-1:0] edit_minutes_q, edit_minutes_d;
  logic                 load_q, load_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [BL_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic                 to_expired, state_change;

  key_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_key_mode (
    .clk     (clk_50MHz),
    .rst     (reset),
    .key_raw (bus.key_mode),
    .pulse   (mode_p)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_key_inc (
    .clk     (clk_50MHz),
    .rst     (reset),
    .key_raw (bus.key_inc),
    .pulse   (inc_p)
  );

  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Priority inside each edit state: MODE, then INC, then timeout.
  always_comb begin
    state_d        = state_q;
    edit_hours_d   = edit_hours_q;
    edit_minutes_d = edit_minutes_q;
    load_d         = 1'b0;
    case (state_q)
      RUN: begin
        if (mode_p) begin
          edit_hours_d   = bus.cur_hours;
          edit_minutes_d = bus.cur_minutes;
          state_d        = SET_HOURS;
        end
      end
      SET_HOURS: begin
        if (mode_p)          state_d      = SET_MINUTES;
        else if (inc_p)      edit_hours_d = inc_hours(edit_hours_q);
        else if (to_expired) state_d      = RUN;
      end
      SET_MINUTES: begin
        if (mode_p) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (inc_p) begin
          edit_minutes_d = inc_minutes(edit_minutes_q);
        end else if (to_expired) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign state_change = (state_d != state_q);

  // Timeout and blink restart on state entry; blink also restarts on INC so edits stay visible.
  always_comb begin
    to_cnt_d      = to_cnt_q + 1'b1;
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (state_change || state_q == RUN || mode_p || inc_p) to_cnt_d = '0;
    if (state_change || state_q == RUN || inc_p) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      edit_hours_q   <= HOURS_RST;
      edit_minutes_q <= MINUTES_RST;
      load_q         <= 1'b0;
      to_cnt_q       <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      edit_hours_q   <= edit_hours_d;
      edit_minutes_q <= edit_minutes_d;
      load_q         <= load_d;
      to_cnt_q       <= to_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
    end
  end

  assign bus.run_en        = (state_q == RUN);
  assign bus.editing       = (state_q != RUN);
  assign bus.load          = load_q;
  assign bus.load_hours    = edit_hours_q;
  assign bus.load_minutes  = edit_minutes_q;
  assign bus.disp_hours    = (state_q == RUN) ? bus.cur_hours   : edit_hours_q;
  assign bus.disp_minutes  = (state_q == RUN) ? bus.cur_minutes : edit_minutes_q;
  assign bus.blank_hours   = blink_phase_q & (state_q == SET_HOURS);
  assign bus.blank_minutes = blink_phase_q & (state_q == SET_MINUTES);

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with shortened debounce/blink/timeout/repeat constants.
module tb_clock_set_controller;

  logic clk_50MHz = 1'b0;
  logic reset     = 1'b1;

  clock_set_controller_if bus();

  clock_set_controller #(
    .DEBOUNCE_CYCLES (4),
    .BLINK_HALF      (8),
    .TIMEOUT_CYCLES  (200),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int checks = 0;
  int errors = 0;

  // Load strobe monitor.
  int         load_cnt     = 0;
  logic [4:0] ld_h         = '0;
  logic [5:0] ld_m         = '0;
  logic       ld_run_en    = 1'b0;
  logic       ld_prev_edit = 1'b0;
  logic       prev_edit    = 1'b0;

  always @(negedge clk_50MHz) begin
    if (bus.load === 1'b1) begin
      load_cnt++;
      ld_h         = bus.load_hours;
      ld_m         = bus.load_minutes;
      ld_run_en    = bus.run_en;
      ld_prev_edit = prev_edit;
    end
    prev_edit = bus.editing;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic press_mode();
    bus.key_mode = 1'b1; tick(10);
    bus.key_mode = 1'b0; tick(10);
  endtask

  task automatic press_inc();
    bus.key_inc = 1'b1; tick(10);
    bus.key_inc = 1'b0; tick(10);
  endtask

  task automatic test_reset();
    bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    bus.cur_hours = 5'd0; bus.cur_minutes = 6'd0;
    reset = 1'b1;
    tick(3);
    checks++; if (bus.run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en: got %b want 1", bus.run_en); end
    checks++; if (bus.load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", bus.load); end
    checks++; if (bus.editing !== 1'b0) begin errors++; $display("FAIL reset_editing: got %b want 0", bus.editing); end
    checks++; if (bus.blank_hours !== 1'b0 || bus.blank_minutes !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b%b want 00", bus.blank_hours, bus.blank_minutes); end
    checks++; if (bus.load_hours !== 5'd12) begin errors++; $display("FAIL reset_edit_hours: got %0d want 12", bus.load_hours); end
    checks++; if (bus.load_minutes !== 6'd0) begin errors++; $display("FAIL reset_edit_minutes: got %0d want 0", bus.load_minutes); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_idle();
    bus.cur_hours = 5'd7; bus.cur_minutes = 6'd45;
    tick(30);
    checks++; if (bus.run_en !== 1'b1) begin errors++; $display("FAIL idle_run_en: got %b want 1", bus.run_en); end
    checks++; if (bus.disp_hours !== 5'd7) begin errors++; $display("FAIL idle_disp_hours: got %0d want 7", bus.disp_hours); end
    checks++; if (bus.disp_minutes !== 6'd45) begin errors++; $display("FAIL idle_disp_minutes: got %0d want 45", bus.disp_minutes); end
    checks++; if (bus.blank_hours !== 1'b0 || bus.blank_minutes !== 1'b0) begin errors++; $display("FAIL idle_blank: got %b%b want 00", bus.blank_hours, bus.blank_minutes); end
    checks++; if (load_cnt !== 0) begin errors++; $display("FAIL idle_no_load: got %0d loads want 0", load_cnt); end
  endtask

  task automatic test_wrap();
    int lc;
    bus.cur_hours = 5'd23; bus.cur_minutes = 6'd58;
    press_mode();
    checks++; if (bus.editing !== 1'b1 || bus.run_en !== 1'b0) begin errors++; $display("FAIL wrap_enter: editing %b run_en %b want 1 0", bus.editing, bus.run_en); end
    checks++; if (bus.disp_hours !== 5'd23 || bus.disp_minutes !== 6'd58) begin errors++; $display("FAIL wrap_capture: got %0d:%0d want 23:58", bus.disp_hours, bus.disp_minutes); end
    press_inc();
    checks++; if (bus.disp_hours !== 5'd0) begin errors++; $display("FAIL wrap_hours: got %0d want 0", bus.disp_hours); end
    press_mode();
    press_inc();
    checks++; if (bus.disp_minutes !== 6'd59) begin errors++; $display("FAIL wrap_min_59: got %0d want 59", bus.disp_minutes); end
    press_inc();
    checks++; if (bus.disp_minutes !== 6'd0) begin errors++; $display("FAIL wrap_min_0: got %0d want 0", bus.disp_minutes); end
    lc = load_cnt;
    press_mode();
    checks++; if (load_cnt !== lc + 1) begin errors++; $display("FAIL wrap_load_count: got %0d want %0d", load_cnt - lc, 1); end
    checks++; if (ld_h !== 5'd0 || ld_m !== 6'd0) begin errors++; $display("FAIL wrap_load_value: got %0d:%0d want 0:0", ld_h, ld_m); end
    checks++; if (ld_run_en !== 1'b1 || ld_prev_edit !== 1'b1) begin errors++; $display("FAIL wrap_load_timing: run_en %b prev_edit %b want 1 1", ld_run_en, ld_prev_edit); end
    checks++; if (bus.editing !== 1'b0 || bus.run_en !== 1'b1) begin errors++; $display("FAIL wrap_back_run: editing %b run_en %b want 0 1", bus.editing, bus.run_en); end
  endtask

  task automatic test_autorepeat();
    int chg[$];
    int exp_off[5] = '{0, 20, 25, 30, 35};
    logic [5:0] prev;
    bit blank_bad;
    int lc;
    bus.cur_hours = 5'd14; bus.cur_minutes = 6'd10;
    press_mode();
    press_mode();
    checks++; if (bus.disp_minutes !== 6'd10 || bus.editing !== 1'b1) begin errors++; $display("FAIL rpt_start: min %0d editing %b want 10 1", bus.disp_minutes, bus.editing); end
    prev = bus.disp_minutes;
    blank_bad = 1'b0;
    bus.key_inc = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (bus.disp_minutes !== prev) begin
        chg.push_back(i);
        if (bus.blank_minutes !== 1'b0) blank_bad = 1'b1;
        prev = bus.disp_minutes;
      end
      if (i == 40) bus.key_inc = 1'b0;
    end
    checks++; if (chg.size() != 5) begin errors++; $display("FAIL rpt_count: got %0d increments want 5", chg.size()); end
    if (chg.size() == 5) begin
      checks++; if (chg[0] != 7) begin errors++; $display("FAIL rpt_first_latency: got %0d want 7", chg[0]); end
      for (int k = 1; k < 5; k++) begin
        checks++; if (chg[k] - chg[0] != exp_off[k]) begin errors++; $display("FAIL rpt_offset%0d: got %0d want %0d", k, chg[k] - chg[0], exp_off[k]); end
      end
    end
    checks++; if (bus.disp_minutes !== 6'd15) begin errors++; $display("FAIL rpt_final: got %0d want 15", bus.disp_minutes); end
    checks++; if (blank_bad !== 1'b0) begin errors++; $display("FAIL rpt_blink_clear: got blanked %b want 0", blank_bad); end
    lc = load_cnt;
    press_mode();
    checks++; if (load_cnt !== lc + 1 || ld_h !== 5'd14 || ld_m !== 6'd15) begin errors++; $display("FAIL rpt_commit: loads %0d value %0d:%0d want 1 14:15", load_cnt - lc, ld_h, ld_m); end
  endtask

  task automatic test_timeout();
    int lc;
    logic e6, e7, e206, e207, b14, b15;
    lc = load_cnt;
    bus.cur_hours = 5'd9; bus.cur_minutes = 6'd30;
    {e6, e7, e206, e207, b14, b15} = '0;
    bus.key_mode = 1'b1;
    for (int i = 1; i <= 220; i++) begin
      tick(1);
      if (i == 10)  bus.key_mode = 1'b0;
      if (i == 6)   e6   = bus.editing;
      if (i == 7)   e7   = bus.editing;
      if (i == 14)  b14  = bus.blank_hours;
      if (i == 15)  b15  = bus.blank_hours;
      if (i == 206) e206 = bus.editing;
      if (i == 207) e207 = bus.editing;
    end
    checks++; if (e6 !== 1'b0 || e7 !== 1'b1) begin errors++; $display("FAIL to_entry_latency: editing@6 %b @7 %b want 0 1", e6, e7); end
    checks++; if (b14 !== 1'b0 || b15 !== 1'b1) begin errors++; $display("FAIL to_blink_phase: blank@14 %b @15 %b want 0 1", b14, b15); end
    checks++; if (e206 !== 1'b1 || e207 !== 1'b0) begin errors++; $display("FAIL to_expiry: editing@206 %b @207 %b want 1 0", e206, e207); end
    checks++; if (load_cnt !== lc) begin errors++; $display("FAIL to_no_load: got %0d loads want 0", load_cnt - lc); end
    checks++; if (bus.run_en !== 1'b1 || bus.disp_hours !== 5'd9 || bus.disp_minutes !== 6'd30) begin errors++; $display("FAIL to_run_disp: run_en %b disp %0d:%0d want 1 9:30", bus.run_en, bus.disp_hours, bus.disp_minutes); end
  endtask

  task automatic test_glitch();
    int found;
    bus.cur_hours = 5'd5; bus.cur_minutes = 6'd20;
    press_mode();
    checks++; if (bus.disp_hours !== 5'd5 || bus.editing !== 1'b1) begin errors++; $display("FAIL glitch_enter: hours %0d editing %b want 5 1", bus.disp_hours, bus.editing); end
    bus.key_inc = 1'b1; tick(3);
    bus.key_inc = 1'b0; tick(15);
    checks++; if (bus.disp_hours !== 5'd5) begin errors++; $display("FAIL glitch_ignored: got %0d want 5", bus.disp_hours); end
    found = -1;
    bus.key_inc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (found < 0 && bus.disp_hours !== 5'd5) found = i;
      if (i == 10) bus.key_inc = 1'b0;
    end
    checks++; if (found != 7) begin errors++; $display("FAIL clean_latency: got %0d want 7", found); end
    checks++; if (bus.disp_hours !== 5'd6) begin errors++; $display("FAIL clean_single_inc: got %0d want 6", bus.disp_hours); end
  endtask

  task automatic test_simultaneous();
    int lc;
    bit seen_bh, seen_bm;
    lc = load_cnt;
    seen_bh = 1'b0; seen_bm = 1'b0;
    bus.key_mode = 1'b1; bus.key_inc = 1'b1;
    tick(10);
    bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.blank_hours === 1'b1)   seen_bh = 1'b1;
      if (bus.blank_minutes === 1'b1) seen_bm = 1'b1;
    end
    checks++; if (bus.editing !== 1'b1) begin errors++; $display("FAIL simul_editing: got %b want 1", bus.editing); end
    checks++; if (bus.disp_hours !== 5'd6 || bus.disp_minutes !== 6'd20) begin errors++; $display("FAIL simul_values: got %0d:%0d want 6:20", bus.disp_hours, bus.disp_minutes); end
    checks++; if (seen_bm !== 1'b1 || seen_bh !== 1'b0) begin errors++; $display("FAIL simul_state: blank_min seen %b blank_hr seen %b want 1 0", seen_bm, seen_bh); end
    reset = 1'b1;
    tick(2);
    checks++; if (bus.editing !== 1'b0 || bus.run_en !== 1'b1 || bus.load !== 1'b0) begin errors++; $display("FAIL midreset_state: editing %b run_en %b load %b want 0 1 0", bus.editing, bus.run_en, bus.load); end
    checks++; if (bus.load_hours !== 5'd12 || bus.load_minutes !== 6'd0) begin errors++; $display("FAIL midreset_edit: got %0d:%0d want 12:0", bus.load_hours, bus.load_minutes); end
    reset = 1'b0;
    tick(5);
    checks++; if (load_cnt !== lc) begin errors++; $display("FAIL midreset_no_load: got %0d loads want 0", load_cnt - lc); end
    checks++; if (bus.disp_hours !== 5'd5 || bus.disp_minutes !== 6'd20) begin errors++; $display("FAIL midreset_disp: got %0d:%0d want 5:20", bus.disp_hours, bus.disp_minutes); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_wrap();
    test_autorepeat();
    test_timeout();
    test_glitch();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
